// File: rtl/instr_load_ctrl_pkg.sv
// Shared CPU definitions: instruction word width and the program-load FSM state encoding.
package instr_load_ctrl_pkg;

    localparam int INST_WIDTH = 32;
    localparam int BIT_CW     = $clog2(INST_WIDTH);

    // Terminal value of the serial bit counter, pre-sized to the counter width.
    localparam logic [BIT_CW-1:0] BIT_LAST = BIT_CW'(INST_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        WRITE,
        DONE,
        RUN
    } load_state_e;

endpackage

// File: rtl/instr_load_ctrl_load_counter.sv
// Bit and word counters for the serial program load, with wrap and terminal flags.
module load_counter
    import instr_load_ctrl_pkg::*;
#(
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          bit_inc_i,
    input  logic          word_inc_i,
    input  logic [AW-1:0] word_max_i,
    output logic [AW-1:0] word_cnt_o,
    output logic          bit_last_o,
    output logic          word_last_o
);

    logic [BIT_CW-1:0] bit_cnt_q, bit_cnt_d;
    logic [AW-1:0]     word_cnt_q, word_cnt_d;

    assign bit_last_o  = (bit_cnt_q == BIT_LAST);
    assign word_last_o = (word_cnt_q == word_max_i);
    assign word_cnt_o  = word_cnt_q;

    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        word_cnt_d = word_cnt_q;
        if (clr_i) begin
            bit_cnt_d  = '0;
            word_cnt_d = '0;
        end else begin
            if (bit_inc_i) begin
                bit_cnt_d = bit_last_o ? '0 : bit_cnt_q + 1'b1;
            end
            if (word_inc_i) begin
                word_cnt_d = word_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            word_cnt_q <= word_cnt_d;
        end
    end

endmodule

// File: rtl/instr_load_ctrl.sv
// Serial program loader: assembles instruction words into the instruction memory,
// then releases the CPU and arbitrates the shared memory address for fetches.
module instr_load_ctrl
    import instr_load_ctrl_pkg::*;
#(
    parameter int IMEM_DEPTH = 8,
    parameter int AW         = $clog2(IMEM_DEPTH)
) (
    input  logic                  sys_clk,
    input  logic                  sys_reset,
    input  logic                  prog_start,
    input  logic [AW-1:0]         prog_count,
    input  logic                  instr_bit_valid,
    input  logic [INST_WIDTH-1:0] instr_reg,
    output logic                  shift_en,
    output logic                  mem_we,
    output logic [AW-1:0]         mem_addr,
    output logic [INST_WIDTH-1:0] mem_wdata,
    input  logic                  cpu_fetch_req,
    input  logic [AW-1:0]         cpu_fetch_addr,
    output logic                  cpu_fetch_gnt,
    output logic                  cpu_run,
    output logic                  load_busy,
    output logic                  load_done,
    output logic                  overrun
);

    load_state_e   state_q, state_d;
    logic [AW-1:0] count_q, count_d;
    logic          overrun_q, overrun_d;

    logic          cnt_clr, bit_inc, word_inc;
    logic          bit_last, word_last;
    logic [AW-1:0] word_cnt;

    load_counter #(.AW(AW)) u_load_counter (
        .clk        (sys_clk),
        .rst        (sys_reset),
        .clr_i      (cnt_clr),
        .bit_inc_i  (bit_inc),
        .word_inc_i (word_inc),
        .word_max_i (count_q),
        .word_cnt_o (word_cnt),
        .bit_last_o (bit_last),
        .word_last_o(word_last)
    );

    assign overrun = overrun_q;

    // NOTE: every signal driven here gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        overrun_d     = overrun_q;
        cnt_clr       = 1'b0;
        bit_inc       = 1'b0;
        word_inc      = 1'b0;
        shift_en      = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        cpu_fetch_gnt = 1'b0;
        cpu_run       = 1'b0;
        load_busy     = 1'b0;
        load_done     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (prog_start) begin
                    state_d   = SHIFT;
                    count_d   = prog_count;
                    overrun_d = 1'b0;
                    cnt_clr   = 1'b1;
                end
            end
            SHIFT: begin
                load_busy = 1'b1;
                shift_en  = instr_bit_valid;
                bit_inc   = instr_bit_valid;
                if (instr_bit_valid && bit_last) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                // The interface cannot shift while its word is being stored, so a bit here is lost.
                load_busy = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = word_cnt;
                mem_wdata = instr_reg;
                if (instr_bit_valid) begin
                    overrun_d = 1'b1;
                end
                if (word_last) begin
                    state_d = DONE;
                end else begin
                    word_inc = 1'b1;
                    state_d  = SHIFT;
                end
            end
            DONE: begin
                load_done = 1'b1;
                state_d   = RUN;
            end
            RUN: begin
                cpu_run       = 1'b1;
                cpu_fetch_gnt = cpu_fetch_req;
                mem_addr      = cpu_fetch_addr;
                if (prog_start) begin
                    state_d   = SHIFT;
                    count_d   = prog_count;
                    overrun_d = 1'b0;
                    cnt_clr   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

endmodule

// File: tb/tb_instr_load_ctrl.sv
// Randomized self-checking bench for instr_load_ctrl with a serial shift-register interface model.
module tb_instr_load_ctrl;

    localparam int IMEM_DEPTH = 8;
    localparam int AW         = $clog2(IMEM_DEPTH);

    logic          clk = 1'b0;
    logic          rst;
    logic          prog_start = 1'b0;
    logic [AW-1:0] prog_count = '0;
    logic          ser_valid = 1'b0;
    logic          ser_bit = 1'b0;
    logic [31:0]   sr_q;
    logic          shift_en, mem_we, cpu_fetch_gnt, cpu_run, load_busy, load_done, overrun;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_fetch_req = 1'b0;
    logic [AW-1:0] cpu_fetch_addr = '0;

    int n_tests = 0;
    int n_fail  = 0;
    bit ovr_exp = 1'b0;

    logic [31:0]   plan_q[$];
    logic [AW-1:0] cap_addr[$];
    logic [31:0]   cap_data[$];

    instr_load_ctrl #(.IMEM_DEPTH(IMEM_DEPTH)) dut (
        .sys_clk        (clk),
        .sys_reset      (rst),
        .prog_start     (prog_start),
        .prog_count     (prog_count),
        .instr_bit_valid(ser_valid),
        .instr_reg      (sr_q),
        .shift_en       (shift_en),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .cpu_fetch_req  (cpu_fetch_req),
        .cpu_fetch_addr (cpu_fetch_addr),
        .cpu_fetch_gnt  (cpu_fetch_gnt),
        .cpu_run        (cpu_run),
        .load_busy      (load_busy),
        .load_done      (load_done),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    // Serial-to-parallel interface: shifts MSB first whenever the controller enables it.
    always @(posedge clk or posedge rst) begin
        if (rst) sr_q <= '0;
        else if (shift_en) sr_q <= {sr_q[30:0], ser_bit};
    end

    always @(posedge clk) begin
        if (!rst && mem_we) begin
            cap_addr.push_back(mem_addr);
            cap_data.push_back(mem_wdata);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return 64'({shift_en, mem_we, mem_addr, mem_wdata, cpu_fetch_gnt,
                    cpu_run, load_busy, load_done, overrun});
    endfunction

    task automatic send_word(input logic [31:0] word, input int idx, input bit junk);
        for (int i = 31; i >= 0; i--) begin
            int gap;
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                ser_valid      = 1'b0;
                prog_start     = ($urandom_range(0, 3) == 0);
                prog_count     = AW'($urandom);
                cpu_fetch_req  = 1'($urandom);
                cpu_fetch_addr = AW'($urandom);
                #1 check("gap", {load_busy, shift_en, cpu_fetch_gnt, cpu_run}, 4'b1000);
                @(negedge clk);
            end
            prog_start     = 1'b0;
            ser_valid      = 1'b1;
            ser_bit        = word[i];
            cpu_fetch_req  = 1'($urandom);
            cpu_fetch_addr = AW'($urandom);
            #1 check("shift_bit",
                     {load_busy, shift_en, cpu_fetch_gnt, cpu_run, mem_we, overrun, mem_addr},
                     {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, ovr_exp, {AW{1'b0}}});
            @(negedge clk);
        end
        ser_valid     = junk;
        ser_bit       = 1'($urandom);
        cpu_fetch_req = 1'b1;
        #1 check("write_ctl", {mem_we, shift_en, load_busy, cpu_fetch_gnt, load_done, overrun},
                 {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, ovr_exp});
        check("write_addr", mem_addr, idx);
        check("write_data", mem_wdata, word);
        @(negedge clk);
        ser_valid     = 1'b0;
        cpu_fetch_req = 1'b0;
        if (junk) ovr_exp = 1'b1;
    endtask

    // Loads every word of plan_q; bit w of mask drops a serial bit into word w's write cycle.
    task automatic run_load(input logic [31:0] mask);
        int n;
        n = plan_q.size();
        cap_addr.delete();
        cap_data.delete();
        ser_valid  = 1'b0;
        prog_start = 1'b1;
        prog_count = AW'(n - 1);
        @(negedge clk);
        prog_start = 1'b0;
        ovr_exp    = 1'b0;
        #1 check("load_start", {load_busy, cpu_run, overrun, shift_en}, 4'b1000);
        for (int w = 0; w < n; w++) send_word(plan_q[w], w, mask[w]);
        prog_start    = 1'b1;
        prog_count    = AW'($urandom);
        ser_valid     = 1'b1;
        cpu_fetch_req = 1'b1;
        #1 check("done_pulse", {load_done, load_busy, cpu_run, shift_en, cpu_fetch_gnt, mem_addr},
                 {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, {AW{1'b0}}});
        @(negedge clk);
        prog_start    = 1'b0;
        ser_valid     = 1'b0;
        cpu_fetch_req = 1'b0;
        #1 check("run_entry", {cpu_run, load_done, load_busy}, 3'b100);
        check("write_count", cap_addr.size(), n);
        for (int w = 0; w < n && w < cap_addr.size(); w++) begin
            check("wr_addr", cap_addr[w], w);
            check("wr_data", cap_data[w], plan_q[w]);
        end
        check("overrun_final", overrun, ovr_exp);
    endtask

    task automatic run_phase(input int cycles, input bit fetch1_first);
        for (int c = 0; c < cycles; c++) begin
            logic          req;
            logic [AW-1:0] addr;
            req  = 1'($urandom);
            addr = AW'($urandom);
            if (c == 0 && fetch1_first) begin
                req  = 1'b1;
                addr = AW'(1);
            end
            cpu_fetch_req  = req;
            cpu_fetch_addr = addr;
            ser_valid      = 1'($urandom);
            ser_bit        = 1'($urandom);
            #1 check("run_fetch",
                     {cpu_run, cpu_fetch_gnt, mem_we, shift_en, load_busy, overrun, mem_addr},
                     {1'b1, req, 1'b0, 1'b0, 1'b0, ovr_exp, addr});
            @(negedge clk);
        end
        ser_valid     = 1'b0;
        cpu_fetch_req = 1'b0;
    endtask

    initial begin
        logic [31:0] w0, w1;
        int          n;

        rst            = 1'b1;
        ser_valid      = 1'b1;
        cpu_fetch_req  = 1'b1;
        cpu_fetch_addr = AW'(3);
        @(negedge clk);
        #1 check("reset_outputs", outs(), 64'd0);
        @(negedge clk);
        rst       = 1'b0;
        ser_valid = 1'b0;

        repeat (2) begin
            ser_valid     = 1'b1;
            ser_bit       = 1'b1;
            cpu_fetch_req = 1'b1;
            #1 check("idle_quiet", outs(), 64'd0);
            @(negedge clk);
        end
        ser_valid     = 1'b0;
        cpu_fetch_req = 1'b0;

        plan_q = '{32'hABCD1234};
        run_load(32'd0);
        run_phase(6, 1'b1);

        plan_q = '{32'h11111111, 32'h22222222, 32'h33333333};
        run_load(32'd0);
        run_phase(3, 1'b0);

        plan_q = '{$urandom, $urandom, $urandom};
        run_load(32'b010);
        run_phase(4, 1'b0);

        for (int k = 0; k < 4; k++) begin
            n = $urandom_range(1, IMEM_DEPTH);
            plan_q.delete();
            for (int j = 0; j < n; j++) plan_q.push_back($urandom);
            run_load($urandom & ((32'd1 << n) - 1));
            run_phase($urandom_range(2, 5), 1'b0);
        end

        // Reset in the middle of a word after an overrun has been flagged.
        w0 = $urandom;
        w1 = $urandom;
        cap_addr.delete();
        cap_data.delete();
        prog_start = 1'b1;
        prog_count = AW'(1);
        @(negedge clk);
        prog_start = 1'b0;
        ovr_exp    = 1'b0;
        send_word(w0, 0, 1'b1);
        for (int i = 31; i >= 22; i--) begin
            ser_valid = 1'b1;
            ser_bit   = w1[i];
            @(negedge clk);
        end
        cpu_fetch_req = 1'b1;
        #1 check("pre_reset_ovr", {overrun, load_busy}, 2'b11);
        #1 rst = 1'b1;
        #1 check("reset_async", outs(), 64'd0);
        check("abort_writes", cap_addr.size(), 1);
        @(negedge clk);
        rst           = 1'b0;
        ser_valid     = 1'b0;
        cpu_fetch_req = 1'b0;
        ovr_exp       = 1'b0;

        plan_q = '{$urandom};
        run_load(32'd0);
        run_phase(2, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_load_ctrl.md
INSTR_LOAD_CTRL -- requirements
Module: instr_load_ctrl

Interface
REQ-001 SHALL have parameter IMEM_DEPTH, default 8: instruction memory entries; power of two, 2..16.
REQ-002 SHALL have parameter AW, default $clog2(IMEM_DEPTH): memory address width.
REQ-003 SHALL have port sys_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port sys_reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port prog_start  input  1  single-cycle request to begin a program load.
REQ-006 SHALL have port prog_count  input  AW  number of instructions to load, minus one; sampled at prog_start.
REQ-007 SHALL have port instr_bit_valid  input  1  serial bit on the instr_reg_interface input is valid this cycle.
REQ-008 SHALL have port instr_reg  input  INST_WIDTH  assembled word from instr_reg_interface.
REQ-009 SHALL have port shift_en  output  1  shift-enable to instr_reg_interface.
REQ-010 SHALL have port mem_we  output  1  instruction-memory write strobe.
REQ-011 SHALL have port mem_addr  output  AW  shared memory address (load write or CPU fetch).
REQ-012 SHALL have port mem_wdata  output  INST_WIDTH  write data.
REQ-013 SHALL have port cpu_fetch_req  input  1  CPU fetch request.
REQ-014 SHALL have port cpu_fetch_addr  input  AW  CPU fetch address.
REQ-015 SHALL have port cpu_fetch_gnt  output  1  fetch granted; memory read data valid next cycle.
REQ-016 SHALL have port cpu_run  output  1  CPU released from hold.
REQ-017 SHALL have port load_busy  output  1  load in progress.
REQ-018 SHALL have port load_done  output  1  one-cycle pulse on load completion.
REQ-019 SHALL have port overrun  output  1  sticky: a valid serial bit was dropped.

Function
REQ-020 SHALL implement FSM states IDLE, SHIFT, WRITE, DONE, RUN.
REQ-021 IDLE: prog_start -> SHIFT; latch prog_count; clear bit_cnt, word_cnt, overrun.
REQ-022 SHIFT: shift_en = instr_bit_valid (combinational); each valid bit increments bit_cnt; bits are MSB first.
REQ-023 SHIFT: valid bit with bit_cnt == INST_WIDTH-1 -> WRITE next cycle; bit_cnt wraps to 0.
REQ-024 WRITE (exactly one cycle): mem_we=1, mem_addr=word_cnt, mem_wdata=instr_reg.
REQ-025 WRITE: word_cnt == latched count -> DONE; otherwise word_cnt+1 and -> SHIFT.
REQ-026 WRITE: shift_en=0; instr_bit_valid=1 here drops the bit and sets overrun.
REQ-027 DONE: load_done=1 for one cycle, then -> RUN.
REQ-028 RUN: cpu_run=1; cpu_fetch_gnt=cpu_fetch_req; mem_addr=cpu_fetch_addr; mem_we=0.
REQ-029 Outside RUN: cpu_fetch_gnt=0 and cpu_run=0; fetches stall with no queueing.
REQ-030 load_busy SHALL be 1 in SHIFT and WRITE only.
REQ-031 prog_start in RUN -> SHIFT (reload): cpu_run falls the next cycle; counters and overrun cleared; prog_count re-latched.
REQ-032 prog_start in SHIFT, WRITE or DONE SHALL be ignored.
REQ-033 Serial bits in IDLE, DONE or RUN SHALL be ignored: shift_en=0 and overrun unchanged.
REQ-034 mem_addr SHALL be 0 whenever not in WRITE or RUN.

Reset
REQ-035 sys_reset SHALL force IDLE, bit_cnt=0, word_cnt=0 and latched count=0 immediately.
REQ-036 On reset, every output SHALL be 0.
REQ-037 Reset mid-load SHALL abandon the partial word; memory contents are not cleared.

Structure
REQ-038 INST_WIDTH (32) and the FSM state enum SHALL live in the shared CPU package.
REQ-039 Sub-module load_counter SHALL hold bit_cnt and word_cnt with wrap and terminal flags; all other logic SHALL be in the top level.

Verification
REQ-040 Reset, then prog_start with prog_count=0, then 32 bits of 0xABCD1234 -> one write of 0xABCD1234 to addr 0; load_done exactly 2 cycles after the last bit; cpu_run=1 after that.
REQ-041 prog_count=2 with words 0x11111111, 0x22222222, 0x33333333 -> writes to addr 0,1,2 in order; load_busy stays high throughout.
REQ-042 instr_bit_valid held during a WRITE cycle -> overrun=1, shift_en=0 that cycle, and the remaining sequence still completes.
REQ-043 In RUN, cpu_fetch_req with cpu_fetch_addr=1 -> cpu_fetch_gnt=1 and mem_addr=1 the same cycle; a fetch during SHIFT -> cpu_fetch_gnt=0.
REQ-044 sys_reset asserted after 10 bits of a word -> all outputs 0 asynchronously; a fresh load then writes addr 0 correctly.
REQ-045 prog_start in RUN -> cpu_run=0 the next cycle and the reload writes starting at addr 0.
